// File: rtl/control_unit.sv
// Moore FSM controller for the 16-bit processor: owns PC/IR, fetches from a registered ROM, drives datapath controls.
// Optional JUMP instruction (opcode 6) is enabled by defining CU_JUMP_EN.
module control_unit #(
  parameter int         PC_W    = 7,
  parameter logic [2:0] ALU_ADD = 3'd1,
  parameter logic [2:0] ALU_SUB = 3'd2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [15:0]     IM_data,
  output logic [PC_W-1:0] IM_addr,
  output logic [7:0]      D_addr,
  output logic            D_wr,
  output logic            RF_sel,
  output logic            RF_W_en,
  output logic [3:0]      WriteAddr,
  output logic [3:0]      rdAddrA,
  output logic [3:0]      rdAddrB,
  output logic [2:0]      ALU_s0,
  output logic [PC_W-1:0] PC_out,
  output logic [15:0]     IR_out,
  output logic [3:0]      state_out
);

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD_A = 4'd3,
    ST_LOAD_B = 4'd4,
    ST_STORE  = 4'd5,
    ST_ADD    = 4'd6,
    ST_SUB    = 4'd7,
    ST_HALT   = 4'd8,
    ST_JUMP   = 4'd9,
    ST_WAIT   = 4'd10
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;

  typedef struct packed {
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_sel;
    logic       rf_w_en;
    logic [3:0] wr_addr;
    logic [3:0] rd_a;
    logic [3:0] rd_b;
    logic [2:0] alu;
  } ctrl_t;

  state_t          state_r;
  state_t          state_n_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_n_s;
  logic [15:0]     ir_r;
  logic [15:0]     ir_n_s;
  ctrl_t           ctrl_r;

  // Moore decode; evaluated on the next state/IR so the registered outputs always match the current state.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      ST_INIT, ST_HALT: c = '0;
      default: begin
        c.wr_addr = ir[3:0];
        c.rd_a    = ir[11:8];
        c.rd_b    = ir[7:4];
      end
    endcase
    case (st)
      ST_STORE: begin
        c.d_addr = ir[7:0];
        c.d_wr   = 1'b1;
      end
      ST_LOAD_A: begin
        c.d_addr = ir[11:4];
        c.rf_sel = 1'b1;
      end
      ST_LOAD_B: begin
        c.d_addr  = ir[11:4];
        c.rf_sel  = 1'b1;
        c.rf_w_en = 1'b1;
      end
      ST_ADD: begin
        c.alu     = ALU_ADD;
        c.rf_w_en = 1'b1;
      end
      ST_SUB: begin
        c.alu     = ALU_SUB;
        c.rf_w_en = 1'b1;
      end
      default: begin
        c.d_addr  = 8'h00;
        c.alu     = 3'd0;
      end
    endcase
    return c;
  endfunction

  // Next-state, PC and IR logic.
  always_comb begin
    state_n_s = state_r;
    pc_n_s    = pc_r;
    ir_n_s    = ir_r;
    case (state_r)
      ST_INIT: state_n_s = ST_FETCH;
      ST_FETCH: begin
        ir_n_s    = IM_data;
        pc_n_s    = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        state_n_s = ST_DECODE;
      end
      ST_DECODE: begin
        case (ir_r[15:12])
          OP_NOOP:  state_n_s = ST_FETCH;
          OP_STORE: state_n_s = ST_STORE;
          OP_LOAD:  state_n_s = ST_LOAD_A;
          OP_ADD:   state_n_s = ST_ADD;
          OP_SUB:   state_n_s = ST_SUB;
          OP_HALT:  state_n_s = ST_HALT;
`ifdef CU_JUMP_EN
          OP_JUMP:  state_n_s = ST_JUMP;
`endif
          default:  state_n_s = ST_FETCH;
        endcase
      end
      ST_LOAD_A: state_n_s = ST_LOAD_B;
      ST_LOAD_B: state_n_s = ST_FETCH;
      ST_STORE:  state_n_s = ST_FETCH;
      ST_ADD:    state_n_s = ST_FETCH;
      ST_SUB:    state_n_s = ST_FETCH;
      ST_HALT:   state_n_s = ST_HALT;
`ifdef CU_JUMP_EN
      ST_JUMP: begin
        pc_n_s    = ir_r[PC_W-1:0];
        state_n_s = ST_WAIT;
      end
      // Gives the ROM one edge to present mem[target] before FETCH.
      ST_WAIT:   state_n_s = ST_FETCH;
`endif
      default:   state_n_s = ST_INIT;
    endcase
  end

  // State, PC, IR and registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_INIT;
      pc_r    <= '0;
      ir_r    <= 16'h0000;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_n_s;
      pc_r    <= pc_n_s;
      ir_r    <= ir_n_s;
      ctrl_r  <= decode_ctrl(state_n_s, ir_n_s);
    end
  end

  assign IM_addr   = pc_r;
  assign PC_out    = pc_r;
  assign IR_out    = ir_r;
  assign state_out = state_r;
  assign D_addr    = ctrl_r.d_addr;
  assign D_wr      = ctrl_r.d_wr;
  assign RF_sel    = ctrl_r.rf_sel;
  assign RF_W_en   = ctrl_r.rf_w_en;
  assign WriteAddr = ctrl_r.wr_addr;
  assign rdAddrA   = ctrl_r.rd_a;
  assign rdAddrB   = ctrl_r.rd_b;
  assign ALU_s0    = ctrl_r.alu;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level trace model against a registered ROM.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] im_data;
  logic [6:0]  im_addr;
  logic [7:0]  d_addr;
  logic        d_wr, rf_sel, rf_w_en;
  logic [3:0]  write_addr, rd_addr_a, rd_addr_b;
  logic [2:0]  alu_s0;
  logic [6:0]  pc_out;
  logic [15:0] ir_out;
  logic [3:0]  state_out;

  logic [15:0] rom [128];
  logic [63:0] exp_q [$];
  logic [6:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_halted;
  int          total = 0;
  int          bad = 0;

  control_unit dut (
    .clk(clk), .reset_n(reset_n), .IM_data(im_data), .IM_addr(im_addr),
    .D_addr(d_addr), .D_wr(d_wr), .RF_sel(rf_sel), .RF_W_en(rf_w_en),
    .WriteAddr(write_addr), .rdAddrA(rd_addr_a), .rdAddrB(rd_addr_b),
    .ALU_s0(alu_s0), .PC_out(pc_out), .IR_out(ir_out), .state_out(state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) im_data <= rom[im_addr];

  wire [63:0] obs_w = {4'h0, state_out, im_addr, pc_out, ir_out, d_addr, d_wr, rf_sel, rf_w_en,
                       write_addr, rd_addr_a, rd_addr_b, alu_s0};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected output vector for one cycle; register addresses are blanked in INIT and HALT.
  function automatic logic [63:0] mk(input logic [3:0] st, input logic [6:0] pc, input logic [15:0] ir,
                                     input logic [7:0] da, input logic wr, input logic sel,
                                     input logic we, input logic [2:0] alu);
    logic [11:0] addrs;
    addrs = (st == 4'd0 || st == 4'd8) ? 12'h000 : {ir[3:0], ir[11:8], ir[7:4]};
    return {4'h0, st, pc, pc, ir, da, wr, sel, we, addrs, alu};
  endfunction

  // Append the cycle-by-cycle expectation for the next instruction.
  task automatic gen_instr();
    logic [15:0] ins;
    if (m_halted) begin
      exp_q.push_back(mk(4'd8, m_pc, m_ir, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
      return;
    end
    ins = rom[m_pc];
    exp_q.push_back(mk(4'd1, m_pc, m_ir, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    m_pc = m_pc + 7'd1;
    m_ir = ins;
    exp_q.push_back(mk(4'd2, m_pc, m_ir, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    case (ins[15:12])
      4'h1: exp_q.push_back(mk(4'd5, m_pc, m_ir, ins[7:0], 1'b1, 1'b0, 1'b0, 3'd0));
      4'h2: begin
        exp_q.push_back(mk(4'd3, m_pc, m_ir, ins[11:4], 1'b0, 1'b1, 1'b0, 3'd0));
        exp_q.push_back(mk(4'd4, m_pc, m_ir, ins[11:4], 1'b0, 1'b1, 1'b1, 3'd0));
      end
      4'h3: exp_q.push_back(mk(4'd6, m_pc, m_ir, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1));
      4'h4: exp_q.push_back(mk(4'd7, m_pc, m_ir, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2));
      4'h5: begin
        m_halted = 1'b1;
        exp_q.push_back(mk(4'd8, m_pc, m_ir, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
      end
`ifdef CU_JUMP_EN
      4'h6: begin
        exp_q.push_back(mk(4'd9, m_pc, m_ir, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
        m_pc = ins[6:0];
        exp_q.push_back(mk(4'd10, m_pc, m_ir, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
      end
`endif
      default: ;
    endcase
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    if (exp_q.size() == 0) gen_instr();
    check_eq(tag, obs_w, exp_q.pop_front());
    check_eq({tag, "_excl"}, {63'd0, d_wr & rf_w_en}, 64'd0);
  endtask

  task automatic do_reset();
    logic [63:0] zero_v;
    zero_v = mk(4'd0, 7'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst_async", obs_w, zero_v);
    @(negedge clk);
    check_eq("rst_hold", obs_w, zero_v);
    reset_n = 1'b1;
    #1;
    check_eq("rst_init", obs_w, zero_v);
    exp_q.delete();
    m_pc = 7'd0;
    m_ir = 16'h0000;
    m_halted = 1'b0;
  endtask

  task automatic fill_random(input bit allow_halt);
    logic [15:0] w;
    for (int i = 0; i < 128; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'h5 && !(allow_halt && $urandom_range(0, 3) == 0)) w[15:12] = 4'h0;
      rom[i] = w;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    m_pc = 7'd0;
    m_ir = 16'h0000;
    m_halted = 1'b0;

    // Directed program: LOAD, STORE, ADD, SUB, HALT (random low bits), then 20 halted cycles.
    fill_random(1'b0);
    rom[0] = 16'h2011;
    rom[1] = 16'h116A;
    rom[2] = 16'h3123;
    rom[3] = 16'h4021;
    rom[4] = {4'h5, 12'($urandom)};
    do_reset();
    repeat (35) step("prog");
    check_eq("halt_state", {60'd0, state_out}, 64'd8);
    check_eq("halt_pc", {57'd0, pc_out}, 64'd5);
    do_reset();

    // Reset asserted during LOAD_A must abandon the load with no register write.
    repeat (3) step("load_a");
    check_eq("load_a_state", {60'd0, state_out}, 64'd3);
    do_reset();

    // JUMP to 5 (or NOOP when the feature is absent).
    rom[0] = 16'h6005;
    rom[5] = 16'h3456;
    do_reset();
    repeat (12) step("jump");

    // All-NOOP ROM: PC must wrap from 127 back to 0.
    for (int i = 0; i < 128; i++) rom[i] = {(($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(7, 15))), 12'($urandom)};
    do_reset();
    repeat (300) step("wrap");

    // Random programs with a mid-run reset each.
    for (int p = 0; p < 4; p++) begin
      fill_random(1'b1);
      do_reset();
      repeat ($urandom_range(20, 80)) step("rand_a");
      do_reset();
      repeat (150) step("rand_b");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
